// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, requester indices and word types for the regfile writeback scheduler.
// The macros are the codebase-wide defines; the package re-exports them as typed constants.
`ifndef REGFILE_WB_SCHED_DEFINES
`define REGFILE_WB_SCHED_DEFINES
`define REG_BUS      [63:0]
`define ZERO_WORD    64'h0
`define REG_ADDR_BUS [4:0]
`define NREG         32
`define WB_ALU       0
`define WB_LSU       1
`endif

package regfile_wb_sched_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = `NREG;
    localparam int AW     = 5;
    localparam int NWB    = 2;
    localparam int WB_ALU = `WB_ALU;
    localparam int WB_LSU = `WB_LSU;

    typedef logic `REG_BUS      word_t;
    typedef logic `REG_ADDR_BUS reg_addr_t;

    localparam word_t ZERO_WORD = `ZERO_WORD;

endpackage

// File: rtl/regfile_wb_sched_wb_rr_arbiter.sv
// Two-way round-robin grant for the ALU/LSU writeback requesters.
// The pointer only moves on a grant, so an idle cycle keeps the current preference.
module wb_rr_arbiter
    import regfile_wb_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NWB-1:0] req,
    output logic [NWB-1:0] gnt
);

    logic prefer_lsu_reg;

    always_comb begin
        gnt = '0;
        if (rst) begin
            if (req[WB_ALU] && (!req[WB_LSU] || !prefer_lsu_reg)) begin
                gnt[WB_ALU] = 1'b1;
            end else if (req[WB_LSU]) begin
                gnt[WB_LSU] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prefer_lsu_reg <= 1'b0;
        end else if (gnt[WB_ALU]) begin
            prefer_lsu_reg <= 1'b1;
        end else if (gnt[WB_LSU]) begin
            prefer_lsu_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Regfile write-port scheduler: arbitrates ALU/LSU writebacks onto one registered write
// port and keeps a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREG_P = NREG,
    parameter int AW_P   = AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [AW_P-1:0]   iss_rs1,
    input  logic              iss_rs1_en,
    input  logic [AW_P-1:0]   iss_rs2,
    input  logic              iss_rs2_en,
    input  logic [AW_P-1:0]   iss_rd,
    input  logic              iss_rd_we,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [AW_P-1:0]   wb0_addr,
    input  logic [XLEN_P-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [AW_P-1:0]   wb1_addr,
    input  logic [XLEN_P-1:0] wb1_data,
    output logic              w_ena,
    output logic [AW_P-1:0]   w_addr,
    output logic [XLEN_P-1:0] w_data,
    output logic [NREG_P-1:0] busy,
    output logic              wb_err
);

    logic [NWB-1:0]    gnt;
    logic [AW_P-1:0]   sel_addr;
    logic [XLEN_P-1:0] sel_data;
    logic              any_gnt;
    logic              wr_fire;
    logic              wb_err_set;
    logic              iss_fire;
    logic              rd_nz;

    logic              w_ena_reg;
    logic [AW_P-1:0]   w_addr_reg;
    logic [XLEN_P-1:0] w_data_reg;
    logic [NREG_P-1:0] busy_reg;
    logic [NREG_P-1:0] busy_next;
    logic              wb_err_reg;

    wb_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .req ({wb1_valid, wb0_valid}),
        .gnt (gnt)
    );

    assign wb0_ready = gnt[WB_ALU];
    assign wb1_ready = gnt[WB_LSU];
    assign any_gnt   = |gnt;
    assign sel_addr  = gnt[WB_LSU] ? wb1_addr : wb0_addr;
    assign sel_data  = gnt[WB_LSU] ? wb1_data : wb0_data;

    // x0 writes are consumed by the handshake but never reach the regfile.
    assign wr_fire    = any_gnt && (sel_addr != '0);
    assign wb_err_set = wr_fire && !busy_reg[sel_addr];

    assign rd_nz     = (iss_rd != '0);
    assign iss_ready = rst
                     & ~(iss_rs1_en & busy_reg[iss_rs1])
                     & ~(iss_rs2_en & busy_reg[iss_rs2])
                     & ~(iss_rd_we & rd_nz & busy_reg[iss_rd]);
    assign iss_fire  = iss_valid && iss_ready;

    // Clear comes from the registered write, so it lands on the edge the regfile commits.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG_P; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = iss_fire && iss_rd_we && (iss_rd == AW_P'(gi));
            assign clr_bit = w_ena_reg && (w_addr_reg == AW_P'(gi));
            assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ena_reg  <= 1'b0;
            w_addr_reg <= '0;
            w_data_reg <= XLEN_P'(ZERO_WORD);
            busy_reg   <= '0;
            wb_err_reg <= 1'b0;
        end else begin
            w_ena_reg <= wr_fire;
            if (wr_fire) begin
                w_addr_reg <= sel_addr;
                w_data_reg <= sel_data;
            end
            busy_reg <= busy_next;
            if (wb_err_set) begin
                wb_err_reg <= 1'b1;
            end
        end
    end

    assign w_ena  = w_ena_reg;
    assign w_addr = w_addr_reg;
    assign w_data = w_data_reg;
    assign busy   = busy_reg;
    assign wb_err = wb_err_reg;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench: a rule-level scoreboard model compared every cycle, plus directed
// checks with hand-computed values for reset, RAW/WAW stalls, round-robin, errors and reset.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_rs1_en, iss_rs2_en, iss_rd_we;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [63:0] wb0_data, wb1_data;
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [63:0] w_data;
    logic [31:0] busy;
    logic        wb_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    regfile_wb_sched dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_rs1    (iss_rs1),
        .iss_rs1_en (iss_rs1_en),
        .iss_rs2    (iss_rs2),
        .iss_rs2_en (iss_rs2_en),
        .iss_rd     (iss_rd),
        .iss_rd_we  (iss_rd_we),
        .wb0_valid  (wb0_valid),
        .wb0_ready  (wb0_ready),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_ready  (wb1_ready),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .w_ena      (w_ena),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_busy;
    bit        m_lsu_turn;
    bit        m_wena;
    bit [4:0]  m_waddr;
    bit [63:0] m_wdata;
    bit        m_err;

    function automatic void model_now(output bit g0, output bit g1, output bit rdy);
        bit hazard;
        g0 = 0; g1 = 0; rdy = 0;
        if (rst === 1'b1) begin
            if (wb0_valid && wb1_valid) begin
                g0 = !m_lsu_turn;
                g1 = m_lsu_turn;
            end else begin
                g0 = wb0_valid;
                g1 = wb1_valid;
            end
            hazard = (iss_rs1_en && m_busy[iss_rs1]) || (iss_rs2_en && m_busy[iss_rs2])
                  || (iss_rd_we && iss_rd != 0 && m_busy[iss_rd]);
            rdy = !hazard;
        end
    endfunction

    always @(posedge clk) begin
        bit g0, g1, rdy;
        bit [31:0] nb;
        bit [4:0]  a;
        if (rst !== 1'b1) begin
            m_busy = 0; m_lsu_turn = 0; m_wena = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        end else begin
            model_now(g0, g1, rdy);
            nb = m_busy;
            if (m_wena) nb[m_waddr] = 1'b0;
            if (iss_valid && rdy && iss_rd_we && iss_rd != 0) nb[iss_rd] = 1'b1;
            if (g0 || g1) begin
                a = g1 ? wb1_addr : wb0_addr;
                m_lsu_turn = g0;
                if (a != 0) begin
                    if (!m_busy[a]) m_err = 1'b1;
                    m_waddr = a;
                    m_wdata = g1 ? wb1_data : wb0_data;
                    m_wena  = 1'b1;
                end else begin
                    m_wena = 1'b0;
                end
            end else begin
                m_wena = 1'b0;
            end
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        bit g0, g1, rdy;
        if (chk_en) begin
            model_now(g0, g1, rdy);
            check("iss_ready", 64'(iss_ready), 64'(rdy));
            check("wb0_ready", 64'(wb0_ready), 64'(g0));
            check("wb1_ready", 64'(wb1_ready), 64'(g1));
            check("w_ena", 64'(w_ena), 64'(m_wena));
            check("w_addr", 64'(w_addr), 64'(m_waddr));
            check("w_data", w_data, m_wdata);
            check("busy", 64'(busy), 64'(m_busy));
            check("wb_err", 64'(wb_err), 64'(m_err));
            if (w_ena === 1'b1)
                $display("write x%0d = %h busy=%h err=%0b", w_addr, w_data, busy, wb_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rs1 = 0; iss_rs1_en = 0; iss_rs2 = 0; iss_rs2_en = 0;
        iss_rd = 0; iss_rd_we = 0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        iss_valid = 1; iss_rs1_en = 0; iss_rs2_en = 0; iss_rd = rd; iss_rd_we = 1;
        #1;
        check("issue_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 0; iss_rd_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit pend0, pend1;
        idle_inputs();
        rst = 0;
        iss_valid = 1; wb0_valid = 1; wb1_valid = 1; wb0_addr = 3; wb1_addr = 4;
        iss_rd = 6; iss_rd_we = 1;
        @(posedge clk);
        chk_en = 1;
        #1;
        repeat (2) tick();
        $display("reset held 3 cycles");
        check("rst_iss_ready", 64'(iss_ready), 64'd0);
        check("rst_wb0_ready", 64'(wb0_ready), 64'd0);
        check("rst_wb1_ready", 64'(wb1_ready), 64'd0);
        check("rst_w_ena", 64'(w_ena), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wb_err", 64'(wb_err), 64'd0);

        // RAW stall on x5 and writeback latency
        idle_inputs();
        rst = 1;
        $display("issue rd=5");
        issue_rd(5'd5);
        check("raw_busy_set", 64'(busy), 64'h20);
        iss_valid = 1; iss_rs1 = 5; iss_rs1_en = 1;
        wb0_valid = 1; wb0_addr = 5; wb0_data = 64'hDEAD_BEEF;
        #1;
        check("raw_stall", 64'(iss_ready), 64'd0);
        check("raw_wb0_grant", 64'(wb0_ready), 64'd1);
        tick();
        wb0_valid = 0;
        #1;
        check("raw_w_ena", 64'(w_ena), 64'd1);
        check("raw_w_addr", 64'(w_addr), 64'd5);
        check("raw_w_data", w_data, 64'hDEAD_BEEF);
        check("raw_still_stalled", 64'(iss_ready), 64'd0);
        tick();
        check("raw_busy_clear", 64'(busy), 64'd0);
        check("raw_issue_ok", 64'(iss_ready), 64'd1);
        tick();
        idle_inputs();

        // WAW stall and x0 destination
        $display("issue rd=7");
        issue_rd(5'd7);
        iss_valid = 1; iss_rd = 7; iss_rd_we = 1;
        #1;
        check("waw_stall", 64'(iss_ready), 64'd0);
        iss_rd = 0;
        #1;
        check("x0_ready", 64'(iss_ready), 64'd1);
        tick();
        check("x0_no_busy", 64'(busy), 64'h80);
        idle_inputs();
        wb1_valid = 1; wb1_addr = 7; wb1_data = 64'h1;
        tick();
        wb1_valid = 0;
        tick();
        check("waw_clear", 64'(busy), 64'd0);

        // round-robin tie: last grant was LSU, so ALU wins first
        issue_rd(5'd3);
        issue_rd(5'd4);
        check("rr_busy", 64'(busy), 64'h18);
        wb0_valid = 1; wb0_addr = 3; wb0_data = 64'h33;
        wb1_valid = 1; wb1_addr = 4; wb1_data = 64'h44;
        #1;
        check("rr_first_wb0", 64'(wb0_ready), 64'd1);
        check("rr_first_not_wb1", 64'(wb1_ready), 64'd0);
        tick();
        wb0_valid = 0;
        #1;
        check("rr_wr3_addr", 64'(w_addr), 64'd3);
        check("rr_second_wb1", 64'(wb1_ready), 64'd1);
        tick();
        wb1_valid = 0;
        check("rr_wr4_ena", 64'(w_ena), 64'd1);
        check("rr_wr4_addr", 64'(w_addr), 64'd4);
        check("rr_wr4_data", w_data, 64'h44);
        check("rr_busy_mid", 64'(busy), 64'h10);
        tick();
        check("rr_busy_done", 64'(busy), 64'd0);

        // writeback to a non-busy register flags wb_err; x0 write is swallowed
        wb1_valid = 1; wb1_addr = 9; wb1_data = 64'h99;
        tick();
        wb1_valid = 0;
        check("err_w_ena", 64'(w_ena), 64'd1);
        check("err_w_addr", 64'(w_addr), 64'd9);
        check("err_set", 64'(wb_err), 64'd1);
        wb0_valid = 1; wb0_addr = 0; wb0_data = 64'h55;
        #1;
        check("x0_wb_grant", 64'(wb0_ready), 64'd1);
        tick();
        wb0_valid = 0;
        check("x0_wb_no_write", 64'(w_ena), 64'd0);
        tick();
        check("err_sticky", 64'(wb_err), 64'd1);

        // reset while x12 busy and a writeback pending
        issue_rd(5'd12);
        check("mid_busy", 64'(busy), 64'h1000);
        wb0_valid = 1; wb0_addr = 12; wb0_data = 64'h77;
        rst = 0;
        #1;
        check("mid_rst_no_grant", 64'(wb0_ready), 64'd0);
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_w_ena", 64'(w_ena), 64'd0);
        check("mid_rst_err", 64'(wb_err), 64'd0);
        rst = 1; wb0_valid = 0;
        iss_valid = 1; iss_rs1 = 12; iss_rs1_en = 1;
        #1;
        check("post_rst_issue", 64'(iss_ready), 64'd1);
        tick();
        idle_inputs();

        // mixed traffic, model-checked each cycle; losers hold their request
        for (int i = 0; i < 300; i++) begin
            iss_valid  = 1'($urandom_range(0, 1));
            iss_rs1    = 5'($urandom_range(0, 15));
            iss_rs1_en = 1'($urandom_range(0, 1));
            iss_rs2    = 5'($urandom_range(0, 15));
            iss_rs2_en = 1'($urandom_range(0, 1));
            iss_rd     = 5'($urandom_range(0, 15));
            iss_rd_we  = 1'($urandom_range(0, 1));
            if (!pend0) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_addr  = 5'($urandom_range(0, 15));
                wb0_data  = {$urandom, $urandom};
            end
            if (!pend1) begin
                wb1_valid = ($urandom_range(0, 3) != 0);
                wb1_addr  = 5'($urandom_range(0, 15));
                wb1_data  = {$urandom, $urandom};
            end
            #1;
            pend0 = wb0_valid && !wb0_ready;
            pend1 = wb1_valid && !wb1_ready;
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
